seq_restoring_divider_16_8: RTL and testbench

- Iterative unsigned restoring divider: the inverse operation of the 8x8 compressor-tree multipliers.
- Recovers operand b from product and operand a, so the error-evaluation flow can check multiplier outputs in hardware: a·b divided by a should return b with remainder 0 when the multiplier is exact.
- Produces one quotient bit per cycle.
- Valid/ready handshake on both sides; single clock domain.

---
 rtl/seq_restoring_divider_16_8.sv | 134 +++++++++++++
 tb/tb_seq_restoring_divider_16_8.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider_16_8.sv
// Iterative unsigned restoring divider, one quotient bit per cycle, with
// valid/ready handshakes on operand and result sides.
module seq_restoring_divider_16_8 #(
    parameter int DW_N = 16,
    parameter int DW_D = 8
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_N-1:0] dividend,
    input  logic [DW_D-1:0] divisor,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_N-1:0] quotient,
    output logic [DW_D-1:0] remainder,
    output logic            div_by_zero
);

    localparam int CW = $clog2(DW_N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW_N-1:0] dvd_q, dvd_d;
    logic [DW_D-1:0] dvs_q, dvs_d;
    logic [DW_D:0]   prem_q, prem_d;
    logic [DW_N-1:0] quot_q, quot_d;
    logic [DW_D-1:0] rem_q, rem_d;
    logic            dbz_q, dbz_d;

    logic [DW_D:0]   shifted_s;
    logic [DW_D+1:0] trial_s;
    logic            qbit_s;

    // One restoring step: the dividend register shifts out its MSB into the
    // partial remainder and collects quotient bits at its LSB.
    always_comb begin
        shifted_s = {prem_q[DW_D-1:0], dvd_q[DW_N-1]};
        trial_s   = {1'b0, shifted_s} - {2'b00, dvs_q};
        qbit_s    = ~trial_s[DW_D+1];
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d  = dividend;
                    dvs_d  = divisor;
                    prem_d = '0;
                    cnt_d  = '0;
                    if (divisor == {DW_D{1'b0}}) begin
                        quot_d  = {DW_N{1'b1}};
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                prem_d = qbit_s ? trial_s[DW_D:0] : shifted_s;
                dvd_d  = {dvd_q[DW_N-2:0], qbit_s};
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DW_N - 1)) begin
                    // Remainder is below the divisor here, so the low bits suffice.
                    quot_d  = {dvd_q[DW_N-2:0], qbit_s};
                    rem_d   = prem_d[DW_D-1:0];
                    dbz_d   = 1'b0;
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider_16_8.sv
// Directed, table-driven bench for the 16/8 restoring divider.
module tb_seq_restoring_divider_16_8;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    seq_restoring_divider_16_8 dut (
        .CLK(CLK), .RST(RST),
        .in_valid(in_valid), .in_ready(in_ready),
        .dividend(dividend), .divisor(divisor),
        .out_valid(out_valid), .out_ready(out_ready),
        .quotient(quotient), .remainder(remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] dvd;
        logic [7:0]  dvs;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present one operation, wait for its result, capture it and consume it.
    task automatic run_op(input logic [15:0] dvd, input logic [7:0] dvs,
                          output logic [15:0] q, output logic [7:0] r,
                          output logic z, output int lat);
        dividend = dvd;
        divisor  = dvs;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("result_valid", {31'd0, out_valid}, 32'd1);
        q = quotient;
        r = remainder;
        z = div_by_zero;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("consume_in_ready", {31'd0, in_ready}, 32'd1);
        check("consume_out_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        logic [15:0] prod;

        vecs[0] = '{16'd1000,  8'd7,   16'd142,   8'd6,  1'b0, 16};
        vecs[1] = '{16'hFFFF,  8'hFF,  16'h0101,  8'd0,  1'b0, 16};
        vecs[2] = '{16'd5,     8'd10,  16'd0,     8'd5,  1'b0, 16};
        vecs[3] = '{16'hFFFF,  8'd1,   16'hFFFF,  8'd0,  1'b0, 16};
        vecs[4] = '{16'h1234,  8'd0,   16'hFFFF,  8'd0,  1'b1, 0};
        vecs[5] = '{16'd0,     8'd5,   16'd0,     8'd0,  1'b0, 16};
        vecs[6] = '{16'd200,   8'd9,   16'd22,    8'd2,  1'b0, 16};
        vecs[7] = '{16'd65535, 8'd7,   16'd9362,  8'd1,  1'b0, 16};
        vecs[8] = '{16'd255,   8'd16,  16'd15,    8'd15, 1'b0, 16};
        vecs[9] = '{16'd500,   8'd3,   16'd166,   8'd2,  1'b0, 16};

        RST = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dividend = '0;
        divisor = '0;
        tick();
        tick();
        RST = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", {16'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].dvd, vecs[i].dvs, q, r, z, lat);
            check($sformatf("vec%0d_quotient", i), {16'd0, q}, {16'd0, vecs[i].q});
            check($sformatf("vec%0d_remainder", i), {24'd0, r}, {24'd0, vecs[i].r});
            check($sformatf("vec%0d_dbz", i), {31'd0, z}, {31'd0, vecs[i].z});
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
        end

        // Backpressure and busy-ignore: new operands offered during BUSY/DONE.
        dividend = 16'd1000;
        divisor = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        dividend = 16'd500;
        divisor = 8'd3;
        in_valid = 1'b1;
        lat = 2;
        while (!out_valid && lat < 40) begin
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            lat++;
        end
        check("bp_latency", lat, 16);
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_quotient", {16'd0, quotient}, 32'd142);
            check("bp_remainder", {24'd0, remainder}, 32'd6);
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_idle_in_ready", {31'd0, in_ready}, 32'd1);
        check("bp_idle_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("bp_second_accepted", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        check("bp2_latency", lat, 16);
        check("bp2_quotient", {16'd0, quotient}, 32'd166);
        check("bp2_remainder", {24'd0, remainder}, 32'd2);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset in the middle of 1000/7.
        dividend = 16'd1000;
        divisor = 8'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) tick();
        check("mid_busy", {31'd0, in_ready}, 32'd0);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        for (int k = 0; k < 20; k++) begin
            tick();
            check("mid_rst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        run_op(16'd200, 8'd9, q, r, z, lat);
        check("post_rst_quotient", {16'd0, q}, 32'd22);
        check("post_rst_remainder", {24'd0, r}, 32'd2);

        // Multiplier round-trip over a spread of operands.
        for (int a = 1; a <= 255; a += 8) begin
            for (int b = 0; b <= 255; b += 9) begin
                prod = 16'(a * b);
                run_op(prod, 8'(a), q, r, z, lat);
                check($sformatf("rt_q_%0d_%0d", a, b), {16'd0, q}, b);
                check($sformatf("rt_r_%0d_%0d", a, b), {24'd0, r}, 32'd0);
            end
        end
        run_op(16'(255 * 255), 8'd255, q, r, z, lat);
        check("rt_q_255_255", {16'd0, q}, 32'd255);
        check("rt_r_255_255", {24'd0, r}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
